// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Shares the single register-file write port between two writeback requesters:
// req0 (ALU writeback) and req1 (load/memory writeback). Arbitration is round-robin
// on contention, one write is accepted per cycle through valid/ready, and the winner
// is registered into an output stage that drives the register file write inputs.
// Writes to R0 are accepted but never reach the RF; they are only counted.
//
// Ports:
//   clk                  system clock, all state updates on the rising edge
//   rst                  synchronous reset, active-high
//   req0_valid/addr/data ALU writeback request
//   req0_ready           req0 accepted this cycle (combinational)
//   req1_valid/addr/data load/memory writeback request
//   req1_ready           req1 accepted this cycle (combinational)
//   rd_en                core read enable, passed straight through to the RF
//   rf_read_or_write     to RF: [1] read enable, [0] write enable
//   rf_write_addr        to RF write address (registered)
//   rf_write_data        to RF write data (registered)
//   last_grant           requester served by the most recent accept
//   wr_count             committed non-R0 writes, wrapping
//   r0_drop_cnt          accepted R0 writes that were dropped, wrapping
module rf_write_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              rd_en,
   output logic [1:0]        rf_read_or_write,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              last_grant,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  r0_drop_cnt
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   // Grant / accept signals for the current cycle
   logic              gnt0;
   logic              gnt1;
   logic              accept;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              accept_wr;
   logic              accept_r0;

   // Registered state
   logic              last_grant_q, last_grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;
   logic [CNT_W-1:0]  r0_drop_q, r0_drop_d;

   // Round-robin grant. A lone requester always wins; under contention the
   // requester that was not served last wins. Nothing is granted during reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         case ({req1_valid, req0_valid})
            2'b01:   gnt0 = 1'b1;
            2'b10:   gnt1 = 1'b1;
            2'b11: begin
               if (last_grant_q) begin
                  gnt0 = 1'b1;
               end else begin
                  gnt1 = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Grants only ever go to a valid requester, so a grant is an accept.
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign accept     = gnt0 | gnt1;

   always_comb begin
      sel_addr = req0_addr;
      sel_data = req0_data;
      if (gnt1) begin
         sel_addr = req1_addr;
         sel_data = req1_data;
      end
   end

   // R0 is hardwired zero in the RF: such writes are accepted but never issued.
   assign accept_wr = accept & (sel_addr != '0);
   assign accept_r0 = accept & (sel_addr == '0);

   // Next-state for the output stage, round-robin pointer and statistics
   always_comb begin
      last_grant_d = last_grant_q;
      we_d         = accept_wr;
      addr_d       = addr_q;
      data_d       = data_q;
      wr_count_d   = wr_count_q;
      r0_drop_d    = r0_drop_q;

      if (accept) begin
         last_grant_d = gnt1;
      end
      if (accept_wr) begin
         addr_d     = sel_addr;
         data_d     = sel_data;
         wr_count_d = wr_count_q + CntOne;
      end
      if (accept_r0) begin
         r0_drop_d = r0_drop_q + CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // last_grant resets to 1 so req0 wins the first contention
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         wr_count_q   <= '0;
         r0_drop_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         wr_count_q   <= wr_count_d;
         r0_drop_q    <= r0_drop_d;
      end
   end

   // Gating the write enable with rst discards a write still held in the output
   // stage when reset arrives, so it never commits at the reset edge.
   assign rf_read_or_write = {rd_en & ~rst, we_q & ~rst};
   assign rf_write_addr    = addr_q;
   assign rf_write_data    = data_q;
   assign last_grant       = last_grant_q;
   assign wr_count         = wr_count_q;
   assign r0_drop_cnt      = r0_drop_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req0_valid = 1'b0;
   logic [ADDR_W-1:0] req0_addr = '0;
   logic [DATA_W-1:0] req0_data = '0;
   logic              req0_ready;
   logic              req1_valid = 1'b0;
   logic [ADDR_W-1:0] req1_addr = '0;
   logic [DATA_W-1:0] req1_data = '0;
   logic              req1_ready;
   logic              rd_en = 1'b0;
   logic [1:0]        rf_read_or_write;
   logic [ADDR_W-1:0] rf_write_addr;
   logic [DATA_W-1:0] rf_write_data;
   logic              last_grant;
   logic [CNT_W-1:0]  wr_count;
   logic [CNT_W-1:0]  r0_drop_cnt;

   rf_write_arbiter #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req0_valid       (req0_valid),
      .req0_addr        (req0_addr),
      .req0_data        (req0_data),
      .req0_ready       (req0_ready),
      .req1_valid       (req1_valid),
      .req1_addr        (req1_addr),
      .req1_data        (req1_data),
      .req1_ready       (req1_ready),
      .rd_en            (rd_en),
      .rf_read_or_write (rf_read_or_write),
      .rf_write_addr    (rf_write_addr),
      .rf_write_data    (rf_write_data),
      .last_grant       (last_grant),
      .wr_count         (wr_count),
      .r0_drop_cnt      (r0_drop_cnt)
   );

   always #5 clk = ~clk;

   // Register file fed by the DUT; it stores whatever is written, R0 included,
   // so a write leaking to R0 is visible.
   logic [DATA_W-1:0] rf_mem [32] = '{default: '0};
   always @(posedge clk) begin
      if (rf_read_or_write[0]) rf_mem[rf_write_addr] <= rf_write_data;
   end

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int unsigned       due;
   } wr_t;

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   bit          m_last = 1'b1;
   wr_t         exp_q[$];

   // Finish the current cycle: check the output stage against the scoreboard at the
   // falling edge, then advance to just after the next rising edge.
   task automatic end_cycle();
      wr_t w;
      @(negedge clk);
      total++;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
         w = exp_q.pop_front();
         if (rf_read_or_write[0] !== 1'b1 || rf_write_addr !== w.addr ||
             rf_write_data !== w.data) begin
            bad++;
            $display("FAIL rf_write cyc=%0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                     cyc, rf_read_or_write[0], rf_write_addr, rf_write_data, w.addr, w.data);
         end
      end else if (rf_read_or_write[0] !== 1'b0) begin
         bad++;
         $display("FAIL rf_we_idle cyc=%0d: got we=%b addr=%0d, want we=0",
                  cyc, rf_read_or_write[0], rf_write_addr);
      end
      total++;
      if (rf_read_or_write[1] !== (rd_en & ~rst)) begin
         bad++;
         $display("FAIL rd_pass cyc=%0d: got %b, want %b", cyc, rf_read_or_write[1], rd_en & ~rst);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drive one cycle of requests, compare readies with the round-robin model and
   // push the expected RF write (due next cycle) for a non-R0 accept.
   task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        output logic r0, output logic r1);
      logic              e0, e1;
      logic [ADDR_W-1:0] wa;
      wr_t               w;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      #1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst) begin
         if (v0 && v1) begin
            e0 = m_last;
            e1 = ~m_last;
         end else begin
            e0 = v0;
            e1 = v1;
         end
      end
      r0 = req0_ready;
      r1 = req1_ready;
      total++;
      if (r0 !== e0 || r1 !== e1) begin
         bad++;
         $display("FAIL grant cyc=%0d: got ready0=%b ready1=%b, want ready0=%b ready1=%b",
                  cyc, r0, r1, e0, e1);
      end
      if (e0 || e1) begin
         m_last = e1;
         wa = e1 ? a1 : a0;
         if (wa != '0) begin
            w.addr = wa;
            w.data = e1 ? d1 : d0;
            w.due  = cyc + 1;
            exp_q.push_back(w);
         end
      end
      end_cycle();
   endtask

   task automatic idle();
      logic r0, r1;
      drive(1'b0, '0, '0, 1'b0, '0, '0, r0, r1);
   endtask

   task automatic do_reset();
      logic r0, r1;
      exp_q.delete();
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '0, '0, r0, r1);
      rst = 1'b0;
      m_last = 1'b1;
   endtask

   task automatic test_reset();
      logic r0, r1;
      rd_en = 1'b1;
      rst   = 1'b1;
      exp_q.delete();
      // readies must stay low during reset even with both requesters valid
      drive(1'b1, 5'd7, 32'h1111_0001, 1'b1, 5'd9, 32'h2222_0002, r0, r1);
      drive(1'b1, 5'd7, 32'h1111_0001, 1'b1, 5'd9, 32'h2222_0002, r0, r1);
      rst = 1'b0;
      m_last = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      total++;
      if (rf_write_addr !== 5'd0 || rf_write_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_stage: got addr=%0d data=%h, want 0/0", rf_write_addr, rf_write_data);
      end
      total++;
      if (last_grant !== 1'b1) begin
         bad++;
         $display("FAIL reset_last_grant: got %b, want 1", last_grant);
      end
      total++;
      if (wr_count !== 16'd0 || r0_drop_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_counters: got wr=%0d drop=%0d, want 0/0", wr_count, r0_drop_cnt);
      end
   endtask

   task automatic test_single_write();
      logic r0, r1;
      rd_en = 1'b1;
      drive(1'b1, 5'd1, 32'hF0F0_F0F0, 1'b0, '0, '0, r0, r1);
      total++;
      if (r0 !== 1'b1) begin
         bad++;
         $display("FAIL single_ready: got %b, want 1", r0);
      end
      idle();
      total++;
      if (rf_mem[1] !== 32'hF0F0_F0F0) begin
         bad++;
         $display("FAIL single_rf_r1: got %h, want f0f0f0f0", rf_mem[1]);
      end
      total++;
      if (wr_count !== 16'd1 || last_grant !== 1'b0) begin
         bad++;
         $display("FAIL single_stats: got wr=%0d last=%b, want 1/0", wr_count, last_grant);
      end
   endtask

   task automatic test_contention();
      logic r0, r1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'd2, 32'h2222_2222, 1'b1, 5'd3, 32'h3333_3333, r0, r1);
         total++;
         if (r1 !== logic'(i % 2) || r0 !== logic'(1 - i % 2)) begin
            bad++;
            $display("FAIL contention_grant%0d: got ready0=%b ready1=%b, want ready%0d",
                     i, r0, r1, i % 2);
         end
      end
      idle();
      total++;
      if (wr_count !== 16'd4 || last_grant !== 1'b1) begin
         bad++;
         $display("FAIL contention_stats: got wr=%0d last=%b, want 4/1", wr_count, last_grant);
      end
      total++;
      if (rf_mem[2] !== 32'h2222_2222 || rf_mem[3] !== 32'h3333_3333) begin
         bad++;
         $display("FAIL contention_rf: got r2=%h r3=%h, want 22222222/33333333",
                  rf_mem[2], rf_mem[3]);
      end
   endtask

   task automatic test_r0_drop();
      logic r0, r1;
      drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0F0F_0F0F, r0, r1);
      total++;
      if (r1 !== 1'b1) begin
         bad++;
         $display("FAIL r0_ready: got %b, want 1", r1);
      end
      idle();
      total++;
      if (r0_drop_cnt !== 16'd1 || wr_count !== 16'd4) begin
         bad++;
         $display("FAIL r0_stats: got drop=%0d wr=%0d, want 1/4", r0_drop_cnt, wr_count);
      end
      total++;
      if (rf_mem[0] !== 32'd0 || last_grant !== 1'b1) begin
         bad++;
         $display("FAIL r0_rf: got r0=%h last=%b, want 0/1", rf_mem[0], last_grant);
      end
   endtask

   task automatic test_same_addr();
      logic r0, r1;
      logic p0, p1;
      int   n;
      p0 = 1'b1;
      p1 = 1'b1;
      n  = 0;
      while ((p0 || p1) && n < 6) begin
         drive(p0, 5'd31, 32'hAAAA_5555, p1, 5'd31, 32'h5555_AAAA, r0, r1);
         if (n == 0) begin
            total++;
            if (r0 !== 1'b1 || r1 !== 1'b0) begin
               bad++;
               $display("FAIL same_addr_first: got ready0=%b ready1=%b, want req0", r0, r1);
            end
         end
         if (r0) p0 = 1'b0;
         if (r1) p1 = 1'b0;
         n++;
      end
      total++;
      if (p0 || p1) begin
         bad++;
         $display("FAIL same_addr_timeout: pending0=%b pending1=%b, want both served", p0, p1);
      end
      idle();
      total++;
      if (rf_mem[31] !== 32'h5555_AAAA) begin
         bad++;
         $display("FAIL same_addr_rf: got r31=%h, want 5555aaaa", rf_mem[31]);
      end
   endtask

   task automatic test_reset_discard();
      logic r0, r1;
      do_reset();
      drive(1'b1, 5'd4, 32'h1234_5678, 1'b0, '0, '0, r0, r1);
      // the held write is discarded by the reset that follows
      exp_q.delete();
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 5'd6, 32'h6666_6666, r0, r1);
      rst = 1'b0;
      m_last = 1'b1;
      req1_valid = 1'b0;
      total++;
      if (wr_count !== 16'd0 || r0_drop_cnt !== 16'd0 || last_grant !== 1'b1) begin
         bad++;
         $display("FAIL discard_state: got wr=%0d drop=%0d last=%b, want 0/0/1",
                  wr_count, r0_drop_cnt, last_grant);
      end
      idle();
      total++;
      if (rf_mem[4] !== 32'd0) begin
         bad++;
         $display("FAIL discard_rf: got r4=%h, want 0", rf_mem[4]);
      end
   endtask

   task automatic test_wrap();
      logic              r0, r1;
      logic [ADDR_W-1:0] a;
      do_reset();
      rd_en = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         a = ADDR_W'((i % 31) + 1);
         drive(1'b1, a, 32'(i), 1'b0, '0, '0, r0, r1);
      end
      total++;
      if (wr_count !== 16'hFFFF) begin
         bad++;
         $display("FAIL wrap_max: got %h, want ffff", wr_count);
      end
      drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, '0, '0, r0, r1);
      total++;
      if (wr_count !== 16'd0) begin
         bad++;
         $display("FAIL wrap_zero: got %h, want 0", wr_count);
      end
      rd_en = 1'b0;
      idle();
      total++;
      if (rf_read_or_write[1] !== 1'b0 || rf_mem[9] !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL wrap_rd_en: got rd=%b r9=%h, want 0/deadbeef",
                  rf_read_or_write[1], rf_mem[9]);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_r0_drop();
      test_same_addr();
      test_reset_discard();
      test_wrap();
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
